// File: rtl/axis_stat_counter_mc.sv
// axis_stat_counter_mc
//
// Passive multi-channel AXI4-Stream statistics collector. For each of
// CHANNELS monitored streams it counts transferred bytes (popcount of tkeep,
// or one per transfer) and completed frames, plus one shared cycle tick.
// On an external trigger or an internal periodic timer pulse all counters
// are snapshotted together with the tag and serialised as a big-endian
// record onto an M_DATA_WIDTH-wide AXI4-Stream master port.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mon_tkeep         CHANNELS*KEEP_WIDTH monitor byte enables (ch c at [c*KEEP_WIDTH +: KEEP_WIDTH])
//   mon_tvalid/tready/tlast  CHANNELS-wide monitor handshake, bit c = channel c
//   m_axis_*          record output stream; tuser on the last beat flags dropped triggers
//   tag               record tag, sampled at snapshot
//   trigger           single-cycle snapshot request
//   interval          periodic trigger period in cycles, 0 disables the timer
//   clear_on_trigger  restart counters at each snapshot
//   busy              a record is being emitted
module axis_stat_counter_mc #(
    parameter int CHANNELS     = 2,
    parameter int KEEP_WIDTH   = 8,
    parameter int KEEP_ENABLE  = 1,
    parameter int COUNT_WIDTH  = 32,
    parameter int TAG_WIDTH    = 16,
    parameter int M_DATA_WIDTH = 32,
    parameter int SATURATE     = 0,
    localparam int M_KEEP_WIDTH = M_DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*KEEP_WIDTH-1:0] mon_tkeep,
    input  logic [CHANNELS-1:0]            mon_tvalid,
    input  logic [CHANNELS-1:0]            mon_tready,
    input  logic [CHANNELS-1:0]            mon_tlast,
    output logic [M_DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0]        m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    input  logic [TAG_WIDTH-1:0]           tag,
    input  logic                           trigger,
    input  logic [COUNT_WIDTH-1:0]         interval,
    input  logic                           clear_on_trigger,
    output logic                           busy
);

    localparam int TAG_BYTES = TAG_WIDTH / 8;
    localparam int CNT_BYTES = COUNT_WIDTH / 8;
    localparam int REC_BYTES = TAG_BYTES + CNT_BYTES * (1 + 2 * CHANNELS);
    localparam int BEATS     = (REC_BYTES + M_KEEP_WIDTH - 1) / M_KEEP_WIDTH;
    localparam int PAD_BYTES = BEATS * M_KEEP_WIDTH;
    localparam int REM_BYTES = REC_BYTES % M_KEEP_WIDTH;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [M_KEEP_WIDTH-1:0] LAST_KEEP =
        (REM_BYTES == 0) ? {M_KEEP_WIDTH{1'b1}} : M_KEEP_WIDTH'((1 << REM_BYTES) - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [0:0] {S_IDLE, S_OUTPUT} state_t;

    // Counter addition: modulo wrap, or stick at all-ones when saturating.
    function automatic logic [COUNT_WIDTH-1:0] cnt_add(input logic [COUNT_WIDTH-1:0] a,
                                                       input logic [COUNT_WIDTH-1:0] b);
        logic [COUNT_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (SATURATE != 0 && sum[COUNT_WIDTH]) begin
            return {COUNT_WIDTH{1'b1}};
        end
        return sum[COUNT_WIDTH-1:0];
    endfunction

    // Any keep pattern counts, not only contiguous masks.
    function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [COUNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            n = n + COUNT_WIDTH'(k[i]);
        end
        return n;
    endfunction

    state_t state_q, state_d;

    logic [COUNT_WIDTH-1:0]                tick_q;
    logic [CHANNELS-1:0][COUNT_WIDTH-1:0]  bytes_q;
    logic [CHANNELS-1:0][COUNT_WIDTH-1:0]  frames_q;
    logic [CHANNELS-1:0][COUNT_WIDTH-1:0]  ev_bytes;
    logic [CHANNELS-1:0]                   ev_frame;

    logic [COUNT_WIDTH-1:0] timer_q;
    logic                   timer_pulse;
    logic                   eff_trig;
    logic                   snap;
    logic                   drop_q;
    logic                   snap_drop_q;

    logic [PAD_BYTES*8-1:0] rec_now;
    logic [PAD_BYTES*8-1:0] rec_q;
    logic [BEAT_W-1:0]      beat_ptr;
    logic [BEAT_W-1:0]      beat_nxt;

    // Monitor events seen this cycle
    always_comb begin
        ev_bytes = '0;
        ev_frame = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (mon_tvalid[c] && mon_tready[c]) begin
                ev_bytes[c] = (KEEP_ENABLE != 0) ? popcount(mon_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH])
                                                 : COUNT_WIDTH'(1);
                ev_frame[c] = mon_tlast[c];
            end
        end
    end

    // Periodic timer; >= keeps a shrunken interval from being skipped past.
    assign timer_pulse = (interval != '0) && (timer_q >= interval - COUNT_WIDTH'(1));
    assign eff_trig    = trigger | timer_pulse;
    assign snap        = (state_q == S_IDLE) && eff_trig;

    always_ff @(posedge clk) begin
        if (rst || interval == '0 || timer_pulse) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + COUNT_WIDTH'(1);
        end
    end

    // Counters: a clearing snapshot restarts from zero but still keeps this
    // cycle's events, so nothing is lost across the boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q   <= '0;
            bytes_q  <= '0;
            frames_q <= '0;
        end else if (snap && clear_on_trigger) begin
            tick_q <= COUNT_WIDTH'(1);
            for (int c = 0; c < CHANNELS; c++) begin
                bytes_q[c]  <= ev_bytes[c];
                frames_q[c] <= COUNT_WIDTH'(ev_frame[c]);
            end
        end else begin
            tick_q <= cnt_add(tick_q, COUNT_WIDTH'(1));
            for (int c = 0; c < CHANNELS; c++) begin
                bytes_q[c]  <= cnt_add(bytes_q[c], ev_bytes[c]);
                frames_q[c] <= cnt_add(frames_q[c], COUNT_WIDTH'(ev_frame[c]));
            end
        end
    end

    // Drop flag: set by triggers arriving while a record is in flight,
    // handed to the next record and cleared at its snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 1'b0;
        end else if (eff_trig) begin
            drop_q <= (state_q == S_OUTPUT);
        end
    end

    // Record image: record byte i lives at rec_now[8i +: 8], fields big-endian.
    always_comb begin
        rec_now = '0;
        for (int i = 0; i < TAG_BYTES; i++) begin
            rec_now[i*8 +: 8] = tag[(TAG_BYTES-1-i)*8 +: 8];
        end
        for (int i = 0; i < CNT_BYTES; i++) begin
            rec_now[(TAG_BYTES+i)*8 +: 8] = tick_q[(CNT_BYTES-1-i)*8 +: 8];
            for (int c = 0; c < CHANNELS; c++) begin
                rec_now[(TAG_BYTES + CNT_BYTES*(1+2*c) + i)*8 +: 8] =
                    bytes_q[c][(CNT_BYTES-1-i)*8 +: 8];
                rec_now[(TAG_BYTES + CNT_BYTES*(2+2*c) + i)*8 +: 8] =
                    frames_q[c][(CNT_BYTES-1-i)*8 +: 8];
            end
        end
    end

    // Control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (eff_trig) state_d = S_OUTPUT;
            S_OUTPUT: if (m_axis_tvalid && m_axis_tready && m_axis_tlast) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q == S_OUTPUT);
    assign beat_nxt = beat_ptr + BEAT_W'(1);

    // Output beat registers: beat 0 is loaded straight from the live record
    // image at snapshot, later beats from the stored copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            beat_ptr      <= '0;
            rec_q         <= '0;
            snap_drop_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (eff_trig) begin
                        rec_q         <= rec_now;
                        snap_drop_q   <= drop_q;
                        beat_ptr      <= '0;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= rec_now[M_DATA_WIDTH-1:0];
                        m_axis_tkeep  <= (BEATS == 1) ? LAST_KEEP : {M_KEEP_WIDTH{1'b1}};
                        m_axis_tlast  <= (BEATS == 1);
                        m_axis_tuser  <= (BEATS == 1) && drop_q;
                    end
                end
                S_OUTPUT: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tdata  <= '0;
                            m_axis_tkeep  <= '0;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tuser  <= 1'b0;
                        end else begin
                            beat_ptr     <= beat_nxt;
                            m_axis_tdata <= rec_q[beat_nxt*M_DATA_WIDTH +: M_DATA_WIDTH];
                            m_axis_tkeep <= (beat_nxt == LAST_BEAT) ? LAST_KEEP
                                                                    : {M_KEEP_WIDTH{1'b1}};
                            m_axis_tlast <= (beat_nxt == LAST_BEAT);
                            m_axis_tuser <= (beat_nxt == LAST_BEAT) && snap_drop_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_stat_counter_mc.sv
// Testbench for axis_stat_counter_mc: default-parameter instance checked every
// cycle against a transaction-level reference model, plus two 8-bit counter
// instances (saturating and wrapping) for the overflow corner.
module tb_axis_stat_counter_mc;

    localparam int CH = 2;
    localparam int KW = 8;
    localparam int CW = 32;
    localparam int TW = 16;
    localparam int MW = 32;
    localparam int MK = 4;
    localparam int L  = 22;
    localparam int B  = 6;
    localparam longint MASK = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [CH*KW-1:0]     mon_tkeep;
    logic [CH-1:0]        mon_tvalid, mon_tready, mon_tlast;
    logic [MW-1:0]        m_tdata;
    logic [MK-1:0]        m_tkeep;
    logic                 m_tvalid, m_tready, m_tlast, m_tuser;
    logic [TW-1:0]        tag;
    logic                 trigger;
    logic [CW-1:0]        interval;
    logic                 clear_on_trigger;
    logic                 busy;

    logic                 trig8;
    logic [7:0]           interval8;
    logic                 tready8;
    logic [31:0]          s1_tdata, s0_tdata;
    logic [3:0]           s1_tkeep, s0_tkeep;
    logic                 s1_tvalid, s1_tlast, s1_tuser, s1_busy;
    logic                 s0_tvalid, s0_tlast, s0_tuser, s0_busy;

    axis_stat_counter_mc dut (
        .clk(clk), .rst(rst), .mon_tkeep(mon_tkeep), .mon_tvalid(mon_tvalid),
        .mon_tready(mon_tready), .mon_tlast(mon_tlast), .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .tag(tag), .trigger(trigger),
        .interval(interval), .clear_on_trigger(clear_on_trigger), .busy(busy)
    );

    axis_stat_counter_mc #(.COUNT_WIDTH(8), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .mon_tkeep(mon_tkeep), .mon_tvalid(mon_tvalid),
        .mon_tready(mon_tready), .mon_tlast(mon_tlast), .m_axis_tdata(s1_tdata),
        .m_axis_tkeep(s1_tkeep), .m_axis_tvalid(s1_tvalid), .m_axis_tready(tready8),
        .m_axis_tlast(s1_tlast), .m_axis_tuser(s1_tuser), .tag(tag), .trigger(trig8),
        .interval(interval8), .clear_on_trigger(1'b0), .busy(s1_busy)
    );

    axis_stat_counter_mc #(.COUNT_WIDTH(8), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .mon_tkeep(mon_tkeep), .mon_tvalid(mon_tvalid),
        .mon_tready(mon_tready), .mon_tlast(mon_tlast), .m_axis_tdata(s0_tdata),
        .m_axis_tkeep(s0_tkeep), .m_axis_tvalid(s0_tvalid), .m_axis_tready(tready8),
        .m_axis_tlast(s0_tlast), .m_axis_tuser(s0_tuser), .tag(tag), .trigger(trig8),
        .interval(interval8), .clear_on_trigger(1'b0), .busy(s0_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    longint       m_tick, m_timer;
    longint       m_bytes [CH];
    longint       m_frames[CH];
    bit           m_out, m_drop, m_snapdrop;
    int           m_beat;
    byte unsigned m_rec [B*MK];

    function automatic void put_be(input int off, input longint v, input int n);
        for (int i = 0; i < n; i++) m_rec[off+i] = 8'((v >> (8*(n-1-i))) & 8'hFF);
    endfunction

    function automatic void model_update();
        bit pulse, eff;
        if (rst) begin
            m_tick = 0; m_timer = 0; m_out = 0; m_drop = 0; m_snapdrop = 0; m_beat = 0;
            for (int c = 0; c < CH; c++) begin m_bytes[c] = 0; m_frames[c] = 0; end
            for (int i = 0; i < B*MK; i++) m_rec[i] = 0;
            return;
        end
        pulse   = (interval != 0) && (m_timer == longint'(interval) - 1);
        m_timer = (interval == 0 || pulse) ? 0 : m_timer + 1;
        eff     = trigger || pulse;
        if (m_out) begin
            if (eff) m_drop = 1;
            if (m_tready) begin
                if (m_beat == B-1) m_out = 0;
                else m_beat++;
            end
        end else if (eff) begin
            for (int i = 0; i < B*MK; i++) m_rec[i] = 0;
            put_be(0, longint'(tag), 2);
            put_be(2, m_tick, 4);
            for (int c = 0; c < CH; c++) begin
                put_be(6 + 8*c, m_bytes[c], 4);
                put_be(10 + 8*c, m_frames[c], 4);
            end
            m_snapdrop = m_drop;
            m_drop = 0;
            m_out = 1;
            m_beat = 0;
            if (clear_on_trigger) begin
                m_tick = 0;
                for (int c = 0; c < CH; c++) begin m_bytes[c] = 0; m_frames[c] = 0; end
            end
        end
        m_tick = (m_tick + 1) & MASK;
        for (int c = 0; c < CH; c++) begin
            if (mon_tvalid[c] && mon_tready[c]) begin
                m_bytes[c] = (m_bytes[c] + $countones(mon_tkeep[c*KW +: KW])) & MASK;
                if (mon_tlast[c]) m_frames[c] = (m_frames[c] + 1) & MASK;
            end
        end
    endfunction

    task automatic check_outputs();
        logic [31:0] ed;
        chk("tvalid", m_tvalid, m_out);
        chk("busy", busy, m_out);
        if (m_out) begin
            ed = {m_rec[m_beat*4+3], m_rec[m_beat*4+2], m_rec[m_beat*4+1], m_rec[m_beat*4]};
            chk("tdata", m_tdata, ed);
            chk("tkeep", m_tkeep, (m_beat == B-1) ? 4'h3 : 4'hF);
            chk("tlast", m_tlast, (m_beat == B-1));
            chk("tuser", m_tuser, (m_beat == B-1) ? m_snapdrop : 1'b0);
        end
    endtask

    // ---------------- record capture ----------------
    typedef struct {
        longint tick, b0, f0, b1, f1;
        bit     tuser;
        int     cyc;
        int     nbeats;
    } rec_t;

    rec_t         recs[$];
    byte unsigned cur[$];
    byte unsigned last_raw[$];
    logic [3:0]   ckeeps[$];
    logic [3:0]   last_keeps[$];
    logic [7:0]   s1_b0, s0_b0, s1_tk, s1_lk;

    function automatic longint be_cur(input int off, input int n);
        longint v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | longint'(cur[off+i]);
        return v;
    endfunction

    task automatic capture();
        rec_t r;
        if (rst) begin
            cur.delete(); ckeeps.delete();
        end else if (m_tvalid === 1'b1 && m_tready) begin
            for (int j = 0; j < MK; j++) if (m_tkeep[j]) cur.push_back(m_tdata[8*j +: 8]);
            ckeeps.push_back(m_tkeep);
            if (m_tlast) begin
                r.nbeats = ckeeps.size();
                r.tuser  = m_tuser;
                r.cyc    = cyc;
                if (cur.size() == L) begin
                    r.tick = be_cur(2, 4);  r.b0 = be_cur(6, 4);  r.f0 = be_cur(10, 4);
                    r.b1 = be_cur(14, 4);   r.f1 = be_cur(18, 4);
                end else begin
                    r.tick = -1; r.b0 = -1; r.f0 = -1; r.b1 = -1; r.f1 = -1;
                end
                recs.push_back(r);
                last_raw = cur;
                last_keeps = ckeeps;
                cur.delete(); ckeeps.delete();
            end
        end
        if (!rst && s1_tvalid === 1'b1 && !s1_tlast) begin s1_b0 = s1_tdata[31:24]; s1_tk = s1_tdata[23:16]; end
        if (!rst && s1_tvalid === 1'b1 && s1_tlast) s1_lk = {4'h0, s1_tkeep};
        if (!rst && s0_tvalid === 1'b1 && !s0_tlast) s0_b0 = s0_tdata[31:24];
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) check_outputs();
        capture();
        model_update();
        chk_en = chk_en | rst;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic mon_idle();
        mon_tkeep = '0; mon_tvalid = '0; mon_tready = '0; mon_tlast = '0;
    endtask

    task automatic mon_rand();
        mon_tkeep  = 16'($urandom);
        mon_tvalid = 2'($urandom);
        mon_tready = 2'($urandom);
        mon_tlast  = 2'($urandom);
    endtask

    task automatic do_reset();
        rst = 1; trigger = 0; trig8 = 0; mon_idle();
        step(); step();
        rst = 0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy || m_tvalid) && n < budget) begin step(); n++; end
        chk(name, (busy || m_tvalid), 1'b0);
    endtask

    task automatic trig_step();
        trigger = 1; step(); trigger = 0;
    endtask

    typedef struct {
        logic [7:0] keep;
        logic       last;
        longint     exp_b;
        longint     exp_f;
    } pc_vec_t;

    pc_vec_t      pc_tab[7];
    byte unsigned exp1[L] = '{8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00,
                              8'h00, 8'h18, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t1, t3, tick1, n0;
        logic [31:0] held;

        pc_tab[0] = '{8'h81, 1'b0, 64'd2, 64'd0};
        pc_tab[1] = '{8'h0F, 1'b0, 64'd4, 64'd0};
        pc_tab[2] = '{8'hFF, 1'b1, 64'd8, 64'd1};
        pc_tab[3] = '{8'h00, 1'b1, 64'd0, 64'd1};
        pc_tab[4] = '{8'hAA, 1'b0, 64'd4, 64'd0};
        pc_tab[5] = '{8'h80, 1'b1, 64'd1, 64'd1};
        pc_tab[6] = '{8'h3C, 1'b0, 64'd4, 64'd0};

        tag = 16'hBEEF; interval = 0; clear_on_trigger = 0; m_tready = 1;
        interval8 = 0; tready8 = 1;
        s1_b0 = 8'h5A; s0_b0 = 8'h5A; s1_tk = 8'h5A; s1_lk = 8'h5A;
        do_reset();

        // reset values
        chk("rst tvalid", m_tvalid, 1'b0);
        chk("rst tlast", m_tlast, 1'b0);
        chk("rst tuser", m_tuser, 1'b0);
        chk("rst tkeep", m_tkeep, 4'h0);
        chk("rst tdata", m_tdata, 32'h0);
        chk("rst busy", busy, 1'b0);

        // basic record: ch0 three full beats, frame on the third, trigger at tick 10
        for (int i = 0; i < 10; i++) begin
            mon_idle();
            if (i >= 1 && i <= 3) begin
                mon_tvalid[0] = 1; mon_tready[0] = 1; mon_tkeep[7:0] = 8'hFF;
                mon_tlast[0] = (i == 3);
            end
            step();
        end
        mon_idle();
        trig_step();
        wait_idle(40, "t1 idle");
        chk("t1 beats", last_keeps.size(), B);
        for (int i = 0; i < L; i++) chk($sformatf("t1 byte%0d", i), last_raw[i], exp1[i]);
        for (int k = 0; k < B; k++) chk($sformatf("t1 keep%0d", k), last_keeps[k], (k < B-1) ? 4'hF : 4'h3);
        chk("t1 tuser", recs[$].tuser, 1'b0);

        // popcount table on ch1, one transfer per clearing window
        clear_on_trigger = 1;
        foreach (pc_tab[v]) begin
            trig_step();
            wait_idle(40, "pc idle");
            mon_tvalid[1] = 1; mon_tready[1] = 1;
            mon_tkeep[15:8] = pc_tab[v].keep; mon_tlast[1] = pc_tab[v].last;
            step();
            mon_idle();
            step();
            trig_step();
            wait_idle(40, "pc idle2");
            chk($sformatf("pc bytes keep=%0h", pc_tab[v].keep), recs[$].b1, pc_tab[v].exp_b);
            chk($sformatf("pc frames keep=%0h", pc_tab[v].keep), recs[$].f1, pc_tab[v].exp_f);
        end

        // periodic trigger, clearing, full throughput
        interval = 100; clear_on_trigger = 1; m_tready = 1;
        do_reset();
        n0 = recs.size();
        for (int i = 0; i < 420; i++) step();
        interval = 0;
        chk("per nrec", recs.size() - n0, 4);
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("per tick%0d", k), recs[n0+k].tick, 100);
            chk($sformatf("per gap%0d", k), recs[n0+k].cyc - recs[n0+k-1].cyc, 100);
        end
        wait_idle(20, "per idle");

        // dropped trigger while output stalled
        do_reset();
        clear_on_trigger = 1; m_tready = 0;
        mon_tvalid[0] = 1; mon_tready[0] = 1; mon_tkeep[7:0] = 8'h0F;
        step();
        t1 = cyc;
        trig_step();
        held = m_tdata;
        for (int i = 0; i < 20; i++) begin
            trigger = (i == 5);
            step();
        end
        trigger = 0;
        chk("drop hold tdata", m_tdata, held);
        chk("drop hold tvalid", m_tvalid, 1'b1);
        m_tready = 1;
        wait_idle(40, "drop idle");
        chk("drop tuser0", recs[$].tuser, 1'b0);
        for (int i = 0; i < 10; i++) step();
        t3 = cyc;
        trig_step();
        mon_idle();
        wait_idle(40, "drop idle2");
        chk("drop tuser1", recs[$].tuser, 1'b1);
        chk("drop tick span", recs[$].tick, t3 - t1);
        chk("drop bytes span", recs[$].b0, 4 * (t3 - t1));

        // 8-bit counters: saturate vs wrap after 300 single-byte transfers
        do_reset();
        mon_tvalid[0] = 1; mon_tready[0] = 1; mon_tkeep[7:0] = 8'h01;
        for (int i = 0; i < 300; i++) step();
        mon_idle();
        trig8 = 1; step(); trig8 = 0;
        for (int i = 0; i < 5; i++) step();
        chk("sat bytes", s1_b0, 8'hFF);
        chk("wrap bytes", s0_b0, 8'h2C);
        chk("sat tick", s1_tk, 8'hFF);
        chk("sat lastkeep", s1_lk, 8'h07);
        wait_idle(40, "sat idle");

        // free-running: two triggers 50 cycles apart, then reset mid-record
        do_reset();
        clear_on_trigger = 0;
        for (int i = 0; i < 5; i++) step();
        t1 = cyc;
        trig_step();
        wait_idle(40, "fr idle");
        tick1 = recs[$].tick;
        while (cyc < t1 + 50) step();
        trig_step();
        wait_idle(40, "fr idle2");
        chk("fr tick diff", recs[$].tick - tick1, 50);
        n0 = recs.size();
        trig_step();
        step(); step();
        chk("mid tvalid", m_tvalid, 1'b1);
        rst = 1; step(); rst = 0;
        chk("rst mid tvalid", m_tvalid, 1'b0);
        chk("rst mid busy", busy, 1'b0);
        trig_step();
        wait_idle(40, "post idle");
        chk("post nrec", recs.size() - n0, 1);
        chk("post tick", recs[$].tick, 0);
        chk("post bytes", recs[$].b0, 0);
        chk("post frames", recs[$].f0, 0);

        // randomized traffic against the model
        interval = CW'($urandom_range(60, 20));
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            mon_rand();
            m_tready = ($urandom_range(99) < 70);
            trigger = ($urandom_range(99) < 3);
            clear_on_trigger = 1'($urandom);
            tag = 16'($urandom);
            step();
        end
        trigger = 0; interval = 0; m_tready = 1; mon_idle();
        wait_idle(60, "rand idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
